bullet_field: RTL and testbench
===============================

# bullet_field

Multi-slot projectile engine for the fighting box; successor to the single bouncing-ball generator. Holds up to N independent balls, each with its own speed, direction, motion mode and lifetime, and accepts new balls through a valid/ready spawn port. Steps all live balls once per animation strobe and flags contact with the player heart. Sits between the attack-pattern sequencer (spawner) and the renderer / HP logic (consumers of coordinates and `o_hit`).

## Interface
- `N`, 4, number of ball slots (1–16)
- `W`, 16, coordinate width
- `F_WIDTH`, 150, fighting box width
- `F_HEIGHT`, 150, fighting box height
- `FX`, 245, box left x
- `FY`, 230, box top y
- `R`, 5, ball radius (all slots)
- `PH`, 8, player half-size for hit test
- `LIFE`, 600, ball lifetime in animation steps
---
- `i_clk` in 1: base clock. Reset is asynchronous and active-low.
- `i_rst_n` in 1: asynchronous active-low reset.
- `i_ani_stb` in 1: one-cycle animation strobe (one step per frame)
- `i_animate` in 1: motion enable; low freezes motion, lifetime and hit test
- `i_spawn_valid` in 1: spawn request
- `o_spawn_ready` out 1: high when any slot is free
- `i_spawn_x`, `i_spawn_y` in W: start offset inside box
- `i_spawn_sx`, `i_spawn_sy` in 2: speed magnitude 0–3 px/step
- `i_spawn_xdir`, `i_spawn_ydir` in 1: 1 = right/down, 0 = left/up
- `i_spawn_mode` in 1: 0 = bounce, 1 = wrap
- `i_px`, `i_py` in W: player centre
- `o_active` out N: slot live flags
- `o_cx`, `o_cy` out N*W: packed centres, slot k at `[k*W +: W]`
- `o_r` out W: constant R
- `o_hit` out 1: one-cycle hit pulse

## Operation
- Bounds: LO_X=FX+R, HI_X=FX+F_WIDTH-R, LO_Y=FY+R, HI_Y=FY+F_HEIGHT-R. SPAN_X=HI_X-LO_X+1; SPAN_Y is the same form.
- Spawn: handshake when `i_spawn_valid && o_spawn_ready`. The lowest-index free slot loads FX+x / FY+y, with each start coordinate clamped into [LO, HI]. It also loads speed, direction and mode, and sets its lifetime counter to LIFE.
- `o_spawn_ready` is the OR of `~active` over slots. It is combinational from registered flags.
- Step (`i_ani_stb && i_animate`): each active slot computes next = pos ± s in W+1 bits.
  - Bounce mode: if next < LO, pos=LO and dir flips. If next > HI, pos=HI and dir flips.
  - Wrap mode: if next < LO, pos=next+SPAN. If next > HI, pos=next−SPAN.
  - Speed 0 on an axis holds that axis.
- Lifetime: the counter decrements on each step. When a step brings it to 0, the slot clears.
- Hit: on a step, a slot hits when it is active with |cx−px| < R+PH and |cy−py| < R+PH, using positions before that step is applied.
  - Each hitting slot clears.
  - `o_hit` pulses once per step, however many slots hit.
- Precedence in one slot and cycle: hit over expiry over motion.
- A slot freed this cycle is not reusable until the next cycle.
- A slot spawned this cycle is not stepped this cycle.
- Inactive slots drive `o_cx`/`o_cy` = 0.

## Timing
- Reset: all `o_active`=0, all coordinates 0, `o_hit`=0, `o_spawn_ready`=1. Reset is effective immediately, including mid-flight.
- Spawn latency: `o_active[k]` and coordinates are valid 1 cycle after the handshake.
- Step latency: coordinates update 1 cycle after the strobe cycle; `o_hit` and cleared `o_active` appear in the same cycle.
- Spawn and step may occur in the same cycle; both are honoured per the precedence rules.
- `i_animate` low blocks steps only. Spawns are still accepted.

## Structure
- Package `bullet_pkg`: mode encoding (BOUNCE=0, WRAP=1), speed width, and the bound/span localparam function.
- Sub-module `ball_slot`: one slot with position, direction, mode, lifetime, its hit compare and its clear logic, instantiated N times.
- Top level: free-slot priority encoder, spawn handshake, packing, `o_hit` OR-reduce.

## Test plan
- Reset → `o_active`=0, `o_spawn_ready`=1, `o_hit`=0. Assert `i_rst_n` low mid-flight → all slots clear at once.
- Bounce: spawn x=140, y=70, sx=3, right, mode 0 → cx 385, 388, 390 (clamped, dir flips), 387.
- Wrap: spawn x=144, sx=2, right, mode 1 → cx 389, then 250 (391−141).
- Full: 4 spawns → `o_spawn_ready`=0, and a 5th valid is held. With LIFE=2, slot 0 expires after 2 steps, ready rises, and the held request lands in slot 0 the next cycle.
- Hit: player at (320,300), ball at (330,300) with sx=sy=0, step → `o_hit` 1 cycle, `o_active[0]`=0. Two simultaneous hits give a single pulse.
- Freeze: `i_animate`=0 with strobes → coordinates and lifetime unchanged, and a spawn is still accepted.

Source files
------------

// File: rtl/bullet_pkg.sv
// rtl/bullet_pkg.sv - shared types and bound helpers for the bullet field
package bullet_pkg;

    typedef enum logic {BOUNCE = 1'b0, WRAP = 1'b1} mode_e;

    localparam int SPD_W = 2;

    typedef struct packed {
        int lo;
        int hi;
        int span;
    } bounds_t;

    // Legal centre range on one axis for a ball of radius r inside [org, org+size].
    function automatic bounds_t axis_bounds(int org, int size, int r);
        bounds_t b;
        b.lo   = org + r;
        b.hi   = org + size - r;
        b.span = b.hi - b.lo + 1;
        return b;
    endfunction

endpackage

// File: rtl/bullet_field_if.sv
// rtl/bullet_field_if.sv - spawn request port between pattern sequencer and bullet field
interface bullet_field_if import bullet_pkg::*; #(
    parameter int W = 16
);
    logic             i_spawn_valid;
    logic             o_spawn_ready;
    logic [W-1:0]     i_spawn_x;
    logic [W-1:0]     i_spawn_y;
    logic [SPD_W-1:0] i_spawn_sx;
    logic [SPD_W-1:0] i_spawn_sy;
    logic             i_spawn_xdir;
    logic             i_spawn_ydir;
    mode_e            i_spawn_mode;

    modport master (
        output i_spawn_valid, i_spawn_x, i_spawn_y, i_spawn_sx, i_spawn_sy,
               i_spawn_xdir, i_spawn_ydir, i_spawn_mode,
        input  o_spawn_ready
    );

    modport slave (
        input  i_spawn_valid, i_spawn_x, i_spawn_y, i_spawn_sx, i_spawn_sy,
               i_spawn_xdir, i_spawn_ydir, i_spawn_mode,
        output o_spawn_ready
    );
endinterface

// File: rtl/ball_slot.sv
// rtl/ball_slot.sv - one projectile: position, heading, mode, lifetime and heart contact
module ball_slot import bullet_pkg::*; #(
    parameter int      W     = 16,
    parameter int      OX    = 0,
    parameter int      OY    = 0,
    parameter bounds_t BX    = '0,
    parameter bounds_t BY    = '0,
    parameter int      HIT_D = 13,
    parameter int      LIFE  = 600
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             load_i,
    input  logic [W-1:0]     x_i,
    input  logic [W-1:0]     y_i,
    input  logic [SPD_W-1:0] sx_i,
    input  logic [SPD_W-1:0] sy_i,
    input  logic             xdir_i,
    input  logic             ydir_i,
    input  mode_e            mode_i,
    input  logic             step_i,
    input  logic [W-1:0]     px_i,
    input  logic [W-1:0]     py_i,
    output logic             active_o,
    output logic [W-1:0]     cx_o,
    output logic [W-1:0]     cy_o,
    output logic             hit_o
);
    localparam int LW = $clog2(LIFE + 1);
    localparam logic [W+1:0] LOX = (W+2)'(BX.lo);
    localparam logic [W+1:0] HIX = (W+2)'(BX.hi);
    localparam logic [W+1:0] SPX = (W+2)'(BX.span);
    localparam logic [W+1:0] LOY = (W+2)'(BY.lo);
    localparam logic [W+1:0] HIY = (W+2)'(BY.hi);
    localparam logic [W+1:0] SPY = (W+2)'(BY.span);

    logic             active_q, active_d;
    logic [W-1:0]     x_q, x_d, y_q, y_d;
    logic             xdir_q, xdir_d, ydir_q, ydir_d;
    logic [SPD_W-1:0] sx_q, sx_d, sy_q, sy_d;
    mode_e            mode_q, mode_d;
    logic [LW-1:0]    life_q, life_d;
    logic [W-1:0]     dx, dy;
    logic             hit;

    function automatic logic [W-1:0] clamp(input logic [W+1:0] v, input logic [W+1:0] lo,
                                           input logic [W+1:0] hi);
        if (v < lo) return lo[W-1:0];
        if (v > hi) return hi[W-1:0];
        return v[W-1:0];
    endfunction

    // Two guard bits: a leftward step can go below zero when the box hugs the origin.
    function automatic logic [W:0] axis_step(input logic [W-1:0] p, input logic [SPD_W-1:0] s,
                                             input logic dir, input mode_e m,
                                             input logic [W+1:0] lo, input logic [W+1:0] hi,
                                             input logic [W+1:0] span);
        logic [W+1:0] n;
        logic [W-1:0] q;
        logic         nd;
        n  = dir ? ({2'b00, p} + (W+2)'(s)) : ({2'b00, p} - (W+2)'(s));
        q  = n[W-1:0];
        nd = dir;
        if (n[W+1] || n < lo) begin
            if (m == WRAP) q = W'(n + span);
            else begin q = lo[W-1:0]; nd = ~dir; end
        end else if (n > hi) begin
            if (m == WRAP) q = W'(n - span);
            else begin q = hi[W-1:0]; nd = ~dir; end
        end
        return {nd, q};
    endfunction

    assign dx  = (x_q >= px_i) ? x_q - px_i : px_i - x_q;
    assign dy  = (y_q >= py_i) ? y_q - py_i : py_i - y_q;
    assign hit = active_q && step_i && (dx < W'(HIT_D)) && (dy < W'(HIT_D));

    always_comb begin
        active_d = active_q;
        x_d = x_q;  y_d = y_q;
        xdir_d = xdir_q;  ydir_d = ydir_q;
        sx_d = sx_q;  sy_d = sy_q;
        mode_d = mode_q;
        life_d = life_q;
        if (load_i) begin
            active_d = 1'b1;
            x_d      = clamp({2'b00, x_i} + (W+2)'(OX), LOX, HIX);
            y_d      = clamp({2'b00, y_i} + (W+2)'(OY), LOY, HIY);
            xdir_d   = xdir_i;  ydir_d = ydir_i;
            sx_d     = sx_i;    sy_d   = sy_i;
            mode_d   = mode_i;
            life_d   = LW'(LIFE);
        end else if (hit) begin
            active_d = 1'b0;
        end else if (active_q && step_i) begin
            if (life_q == LW'(1)) begin
                active_d = 1'b0;
            end else begin
                {xdir_d, x_d} = axis_step(x_q, sx_q, xdir_q, mode_q, LOX, HIX, SPX);
                {ydir_d, y_d} = axis_step(y_q, sy_q, ydir_q, mode_q, LOY, HIY, SPY);
                life_d        = life_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            active_q <= 1'b0;
            x_q <= '0;  y_q <= '0;
            xdir_q <= 1'b0;  ydir_q <= 1'b0;
            sx_q <= '0;  sy_q <= '0;
            mode_q <= BOUNCE;
            life_q <= '0;
        end else begin
            active_q <= active_d;
            x_q <= x_d;  y_q <= y_d;
            xdir_q <= xdir_d;  ydir_q <= ydir_d;
            sx_q <= sx_d;  sy_q <= sy_d;
            mode_q <= mode_d;
            life_q <= life_d;
        end
    end

    assign active_o = active_q;
    assign cx_o     = active_q ? x_q : '0;
    assign cy_o     = active_q ? y_q : '0;
    assign hit_o    = hit;
endmodule

// File: rtl/bullet_field.sv
// rtl/bullet_field.sv - N-slot projectile engine with spawn port and heart hit pulse
module bullet_field import bullet_pkg::*; #(
    parameter int N        = 4,
    parameter int W        = 16,
    parameter int F_WIDTH  = 150,
    parameter int F_HEIGHT = 150,
    parameter int FX       = 245,
    parameter int FY       = 230,
    parameter int R        = 5,
    parameter int PH       = 8,
    parameter int LIFE     = 600
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_ani_stb,
    input  logic             i_animate,
    bullet_field_if.slave    spawn,
    input  logic [W-1:0]     i_px,
    input  logic [W-1:0]     i_py,
    output logic [N-1:0]     o_active,
    output logic [N*W-1:0]   o_cx,
    output logic [N*W-1:0]   o_cy,
    output logic [W-1:0]     o_r,
    output logic             o_hit
);
    localparam bounds_t BX = axis_bounds(FX, F_WIDTH, R);
    localparam bounds_t BY = axis_bounds(FY, F_HEIGHT, R);

    logic [N-1:0] load;
    logic [N-1:0] slot_hit;
    logic         fire, found, step;
    logic         hit_q, hit_d;

    assign spawn.o_spawn_ready = ~&o_active;
    assign fire = spawn.i_spawn_valid && spawn.o_spawn_ready;
    assign step = i_ani_stb && i_animate;

    // Lowest-index free slot takes the spawn.
    always_comb begin
        load  = '0;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!o_active[k] && !found) begin
                load[k] = fire;
                found   = 1'b1;
            end
        end
    end

    for (genvar k = 0; k < N; k++) begin : g_slot
        ball_slot #(
            .W(W), .OX(FX), .OY(FY), .BX(BX), .BY(BY), .HIT_D(R + PH), .LIFE(LIFE)
        ) u_slot (
            .clk_i    (i_clk),
            .rst_n_i  (i_rst_n),
            .load_i   (load[k]),
            .x_i      (spawn.i_spawn_x),
            .y_i      (spawn.i_spawn_y),
            .sx_i     (spawn.i_spawn_sx),
            .sy_i     (spawn.i_spawn_sy),
            .xdir_i   (spawn.i_spawn_xdir),
            .ydir_i   (spawn.i_spawn_ydir),
            .mode_i   (spawn.i_spawn_mode),
            .step_i   (step),
            .px_i     (i_px),
            .py_i     (i_py),
            .active_o (o_active[k]),
            .cx_o     (o_cx[k*W +: W]),
            .cy_o     (o_cy[k*W +: W]),
            .hit_o    (slot_hit[k])
        );
    end

    assign hit_d = |slot_hit;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) hit_q <= 1'b0;
        else          hit_q <= hit_d;
    end

    assign o_hit = hit_q;
    assign o_r   = W'(R);
endmodule

// File: tb/tb_bullet_field.sv
// tb/tb_bullet_field.sv - scoreboard bench for bullet_field against a behavioural model
module tb_bullet_field;
    import bullet_pkg::*;

    localparam int N = 4, W = 16, LIFE = 8;
    localparam int FX = 245, FY = 230, FW = 150, FH = 150, R = 5, PH = 8;
    localparam int LO_X = FX + R, HI_X = FX + FW - R, LO_Y = FY + R, HI_Y = FY + FH - R;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           stb, anim;
    logic [W-1:0]   px, py;
    logic [N-1:0]   act;
    logic [N*W-1:0] cx, cy;
    logic [W-1:0]   r;
    logic           hit;

    bullet_field_if #(.W(W)) sp();

    bullet_field #(.N(N), .W(W), .LIFE(LIFE)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_ani_stb(stb), .i_animate(anim), .spawn(sp),
        .i_px(px), .i_py(py), .o_active(act), .o_cx(cx), .o_cy(cy), .o_r(r), .o_hit(hit)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0]   act;
        logic [N*W-1:0] cx;
        logic [N*W-1:0] cy;
        logic           hit;
        logic           rdy;
    } exp_t;
    exp_t sb[$];

    int n_tests = 0, n_fail = 0;
    int ppx_g = 0, ppy_g = 0;
    int m_act[N], m_x[N], m_y[N], m_xd[N], m_yd[N], m_sx[N], m_sy[N], m_wrap[N], m_life[N];
    int m_hit = 0;

    task automatic check(input string name, input logic [63:0] a, input logic [63:0] e);
        n_tests++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, a, e);
        end
    endtask

    function automatic int iabs(int v); return (v < 0) ? -v : v; endfunction
    function automatic int clampi(int v, int lo, int hi);
        return (v < lo) ? lo : ((v > hi) ? hi : v);
    endfunction
    function automatic int model_rdy();
        foreach (m_act[k]) if (m_act[k] == 0) return 1;
        return 0;
    endfunction

    task automatic move(inout int p, inout int d, input int s, input int wrap, input int lo, input int hi);
        int n;
        n = (d != 0) ? p + s : p - s;
        if (n < lo || n > hi) begin
            if (wrap != 0) p = (n < lo) ? n + (hi - lo + 1) : n - (hi - lo + 1);
            else begin p = (n < lo) ? lo : hi; d = (d == 0) ? 1 : 0; end
        end else p = n;
    endtask

    task automatic model_cycle(int s_step, int sv, int x, int y, int sx, int sy, int xd, int yd, int md);
        int slot = -1;
        if (sv != 0 && model_rdy() != 0)
            foreach (m_act[k]) if (m_act[k] == 0 && slot < 0) slot = k;
        m_hit = 0;
        if (s_step != 0)
            foreach (m_act[k]) if (m_act[k] != 0) begin
                if (iabs(m_x[k] - ppx_g) < R + PH && iabs(m_y[k] - ppy_g) < R + PH) begin
                    m_act[k] = 0; m_hit = 1;
                end else if (m_life[k] == 1) m_act[k] = 0;
                else begin
                    move(m_x[k], m_xd[k], m_sx[k], m_wrap[k], LO_X, HI_X);
                    move(m_y[k], m_yd[k], m_sy[k], m_wrap[k], LO_Y, HI_Y);
                    m_life[k]--;
                end
            end
        if (slot >= 0) begin
            m_act[slot] = 1; m_life[slot] = LIFE;
            m_x[slot] = clampi(FX + x, LO_X, HI_X); m_y[slot] = clampi(FY + y, LO_Y, HI_Y);
            m_sx[slot] = sx; m_sy[slot] = sy; m_xd[slot] = xd; m_yd[slot] = yd; m_wrap[slot] = md;
        end
    endtask

    task automatic push_exp();
        exp_t e;
        e.act = '0; e.cx = '0; e.cy = '0;
        for (int k = 0; k < N; k++) begin
            e.act[k] = (m_act[k] != 0);
            e.cx[k*W +: W] = (m_act[k] != 0) ? W'(m_x[k]) : '0;
            e.cy[k*W +: W] = (m_act[k] != 0) ? W'(m_y[k]) : '0;
        end
        e.hit = (m_hit != 0);
        e.rdy = (model_rdy() != 0);
        sb.push_back(e);
    endtask

    task automatic drive(int s_stb, int s_anim, int sv, int x, int y, int sx, int sy, int xd, int yd, int md);
        stb = (s_stb != 0); anim = (s_anim != 0);
        sp.i_spawn_valid = (sv != 0);
        sp.i_spawn_x = W'(x); sp.i_spawn_y = W'(y);
        sp.i_spawn_sx = 2'(sx); sp.i_spawn_sy = 2'(sy);
        sp.i_spawn_xdir = (xd != 0); sp.i_spawn_ydir = (yd != 0);
        sp.i_spawn_mode = (md != 0) ? WRAP : BOUNCE;
        px = W'(ppx_g); py = W'(ppy_g);
        model_cycle((s_stb != 0 && s_anim != 0) ? 1 : 0, sv, x, y, sx, sy, xd, yd, md);
        push_exp();
        @(negedge clk);
    endtask

    task automatic steps(int n);
        for (int i = 0; i < n; i++) drive(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; stb = 1'b0; sp.i_spawn_valid = 1'b0;
        foreach (m_act[k]) m_act[k] = 0;
        m_hit = 0;
        #1;
        check("rst_active", 64'(act), 64'(0));
        check("rst_ready", 64'(sp.o_spawn_ready), 64'(1));
        check("rst_hit", 64'(hit), 64'(0));
        check("rst_cx", 64'(cx), 64'(0));
        push_exp();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial forever begin
        @(posedge clk); #1;
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            check("mon_active", 64'(act), 64'(e.act));
            check("mon_cx", 64'(cx), 64'(e.cx));
            check("mon_cy", 64'(cy), 64'(e.cy));
            check("mon_hit", 64'(hit), 64'(e.hit));
            check("mon_ready", 64'(sp.o_spawn_ready), 64'(e.rdy));
        end
    end

    initial begin
        rst_n = 1'b0; stb = 1'b0; anim = 1'b1; px = '0; py = '0;
        sp.i_spawn_valid = 1'b0; sp.i_spawn_x = '0; sp.i_spawn_y = '0;
        sp.i_spawn_sx = '0; sp.i_spawn_sy = '0; sp.i_spawn_xdir = 1'b0; sp.i_spawn_ydir = 1'b0;
        sp.i_spawn_mode = BOUNCE;
        @(negedge clk);
        do_reset();
        check("o_r", 64'(r), 64'(R));

        drive(0, 1, 1, 140, 70, 3, 0, 1, 0, 0);
        check("bounce_spawn", 64'(cx[0 +: W]), 64'(385));
        check("bounce_act", 64'(act), 64'(1));
        steps(1); check("bounce_s1", 64'(cx[0 +: W]), 64'(388));
        steps(1); check("bounce_s2", 64'(cx[0 +: W]), 64'(390));
        steps(1); check("bounce_s3", 64'(cx[0 +: W]), 64'(387));
        do_reset();

        drive(0, 1, 1, 144, 70, 2, 0, 1, 0, 1);
        check("wrap_spawn", 64'(cx[0 +: W]), 64'(389));
        steps(1); check("wrap_s1", 64'(cx[0 +: W]), 64'(250));
        do_reset();

        ppx_g = 320; ppy_g = 300;
        drive(0, 1, 1, 85, 70, 0, 0, 0, 0, 0);
        steps(1);
        check("hit_pulse", 64'(hit), 64'(1));
        check("hit_clear", 64'(act), 64'(0));
        drive(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        check("hit_drop", 64'(hit), 64'(0));
        drive(0, 1, 1, 85, 70, 0, 0, 0, 0, 0);
        drive(0, 1, 1, 75, 70, 0, 0, 0, 0, 0);
        steps(1);
        check("hit2_pulse", 64'(hit), 64'(1));
        check("hit2_clear", 64'(act), 64'(0));
        drive(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        check("hit2_drop", 64'(hit), 64'(0));
        ppx_g = 0; ppy_g = 0;
        do_reset();

        drive(0, 1, 1, 10, 10, 0, 0, 0, 0, 0);
        for (int i = 1; i < 4; i++) drive(1, 1, 1, 10 + 20 * i, 10, 0, 0, 0, 0, 0);
        check("full_act", 64'(act), 64'(15));
        check("full_ready", 64'(sp.o_spawn_ready), 64'(0));
        for (int i = 0; i < 5; i++) drive(1, 1, 1, 100, 100, 1, 1, 1, 1, 0);
        check("expire_act", 64'(act), 64'(14));
        check("expire_ready", 64'(sp.o_spawn_ready), 64'(1));
        drive(0, 1, 1, 100, 100, 1, 1, 1, 1, 0);
        check("held_land", 64'(act), 64'(15));
        check("held_cx", 64'(cx[0 +: W]), 64'(345));
        do_reset();

        drive(0, 1, 1, 50, 10, 1, 1, 1, 1, 0);
        drive(1, 0, 1, 60, 20, 1, 1, 1, 1, 0);
        check("frz_spawn", 64'(act), 64'(3));
        for (int i = 0; i < 3; i++) drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        check("frz_cx", 64'(cx[0 +: W]), 64'(295));
        steps(LIFE - 1);
        check("frz_life_alive", 64'(act), 64'(3));
        steps(1);
        check("frz_life_end", 64'(act), 64'(0));

        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) do_reset();
            ppx_g = $urandom_range(FX, FX + FW);
            ppy_g = $urandom_range(FY, FY + FH);
            drive($urandom_range(0, 1), ($urandom_range(0, 3) > 0) ? 1 : 0, $urandom_range(0, 1),
                  $urandom_range(0, 160), $urandom_range(0, 160), $urandom_range(0, 3),
                  $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 1),
                  $urandom_range(0, 1));
        end
        drive(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        check("sb_drain", 64'(sb.size()), 64'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
